siso_seq: RTL and testbench

Sequencer for an external serial-in/serial-out shift-register chain. It accepts a parallel word over a valid/ready handshake and shifts it into the chain bit by bit. It then clocks the chain for DEPTH more cycles, captures the bits leaving the chain back into a parallel word, and presents that word over a second valid/ready handshake. It sits between the parallel datapath and the SISO delay/transport chain, and is the only driver of the chain's shift enable and serial input.

---
 rtl/siso_seq_pkg.sv | 28 ++
 rtl/siso_seq_if.sv | 38 +++
 rtl/siso_seq_cnt.sv | 40 ++++
 rtl/siso_seq.sv | 178 +++++++++++++++++
 tb/tb_siso_seq.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/siso_seq_pkg.sv
// Shared types and elaboration helpers for the SISO chain sequencer.
package siso_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Minimum bit count able to hold 0..n-1; never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < n) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  // Map a serial position onto a word bit index for the chosen bit order.
  function automatic int order_pos(input int pos, input int width, input logic msb_first);
    return msb_first ? (width - 1 - pos) : pos;
  endfunction

endpackage

// File: rtl/siso_seq_if.sv
// Parallel handshakes plus chain-control bundle of siso_seq.
// Optional mismatch flag appears when SISO_SEQ_CHECK_EN is defined.
interface siso_seq_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             sr_en;
  logic             sr_din;
  logic             sr_dout;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
`ifdef SISO_SEQ_CHECK_EN
  logic             mismatch;
`endif

  modport slave (
    input  in_data, in_valid, sr_dout, out_ready,
    output in_ready, sr_en, sr_din, out_data, out_valid,
`ifdef SISO_SEQ_CHECK_EN
    output mismatch,
`endif
    output busy
  );

  modport master (
    output in_data, in_valid, sr_dout, out_ready,
    input  in_ready, sr_en, sr_din, out_data, out_valid,
`ifdef SISO_SEQ_CHECK_EN
    input  mismatch,
`endif
    input  busy
  );

endinterface

// File: rtl/siso_seq_cnt.sv
// Phase counter k for the SHIFT/FLUSH span; wraps to 0 after its last phase.
module siso_seq_cnt #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_k,
  output logic          o_last_w,
  output logic          o_last
);

  localparam logic [CW-1:0] K_LAST_W = CW'(WIDTH - 1);
  localparam logic [CW-1:0] K_LAST   = CW'(WIDTH + DEPTH - 1);

  logic [CW-1:0] r_k;

  // Phase register: cleared outside the enable span, wraps after the final flush phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k <= {CW{1'b0}};
    end else if (i_clr) begin
      r_k <= {CW{1'b0}};
    end else if (i_en) begin
      if (r_k == K_LAST) begin
        r_k <= {CW{1'b0}};
      end else begin
        r_k <= r_k + CW'(1);
      end
    end
  end

  assign o_k      = r_k;
  assign o_last_w = (r_k == K_LAST_W);
  assign o_last   = (r_k == K_LAST);

endmodule

// File: rtl/siso_seq.sv
// Sequencer that streams a word through an external SISO chain and captures it back.
// Build option: SISO_SEQ_CHECK_EN adds the sent-vs-captured mismatch flag.
module siso_seq
  import siso_seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input logic       clk,
  input logic       rst,
  siso_seq_if.slave bus
);

  localparam int CW = clog2(WIDTH + DEPTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    w_k;
  logic             w_last_w;
  logic             w_last;
  logic             w_run;
  logic             w_accept;
  logic             w_done;
  logic [CW-1:0]    r_ph;
  logic [WIDTH-1:0] r_send;
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] w_cap_nxt;
  logic [WIDTH-1:0] w_cap_mask;
  logic [WIDTH-1:0] w_shifted;
  logic             w_send_bit;
  logic             w_cap_en;
  int               w_din_pos;
  int               w_cap_pos;
  logic             r_in_ready;
  logic             r_sr_en;
  logic             r_sr_din;
  logic             r_out_valid;
  logic             r_busy;

  assign w_run = (r_state == SHIFT) || (r_state == FLUSH);

  siso_seq_cnt #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (!w_run),
    .i_en     (w_run),
    .o_k      (w_k),
    .o_last_w (w_last_w),
    .o_last   (w_last)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode with accept/complete strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid && r_in_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (w_last_w) begin
          w_state_nxt = FLUSH;
        end else begin
          w_state_nxt = SHIFT;
        end
      end
      FLUSH: begin
        if (w_last) begin
          w_state_nxt = HOLD;
        end else begin
          w_state_nxt = FLUSH;
        end
      end
      HOLD: begin
        if (r_out_valid && bus.out_ready) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Serial bit selection and capture merge. Outputs trail the phase counter by
  // one register, so r_ph names the phase of the enable cycle now on the chain.
  always_comb begin
    w_din_pos  = order_pos(int'(w_k), WIDTH, MSB_FIRST != 0);
    w_shifted  = r_send >> w_din_pos;
    w_send_bit = w_shifted[0];
    w_cap_en   = r_sr_en && (int'(r_ph) >= DEPTH);
    w_cap_pos  = order_pos(int'(r_ph) - DEPTH, WIDTH, MSB_FIRST != 0);
    if (w_cap_en) begin
      w_cap_mask = WIDTH'(1) << w_cap_pos;
    end else begin
      w_cap_mask = {WIDTH{1'b0}};
    end
    w_cap_nxt = (r_cap & ~w_cap_mask) | (w_cap_mask & {WIDTH{bus.sr_dout}});
  end

  // Registered datapath and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_send      <= {WIDTH{1'b0}};
      r_cap       <= {WIDTH{1'b0}};
      r_ph        <= {CW{1'b0}};
      r_in_ready  <= 1'b0;
      r_sr_en     <= 1'b0;
      r_sr_din    <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_send <= bus.in_data;
      end
      r_cap      <= w_cap_nxt;
      r_ph       <= w_k;
      r_sr_en    <= w_run;
      r_sr_din   <= (r_state == SHIFT) ? w_send_bit : 1'b0;
      r_in_ready <= (w_state_nxt == IDLE);
      r_busy     <= (w_state_nxt != IDLE);
      // The last enable cycle is still on the chain when HOLD is entered.
      if (w_done) begin
        r_out_valid <= 1'b0;
      end else if ((r_state == HOLD) && r_sr_en) begin
        r_out_valid <= 1'b1;
      end
    end
  end

`ifdef SISO_SEQ_CHECK_EN
  logic r_mismatch;

  // Compare flag, sampled alongside the final captured bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mismatch <= 1'b0;
    end else if (w_done) begin
      r_mismatch <= 1'b0;
    end else if ((r_state == HOLD) && r_sr_en) begin
      r_mismatch <= (w_cap_nxt != r_send);
    end
  end

  assign bus.mismatch = r_mismatch;
`endif

  assign bus.in_ready  = r_in_ready;
  assign bus.sr_en     = r_sr_en;
  assign bus.sr_din    = r_sr_din;
  assign bus.out_data  = r_cap;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_siso_seq.sv
// Scoreboard bench for siso_seq: two instances (MSB-first and LSB-first) on ideal chain models.
module tb_siso_seq;

  localparam int W = 8;
  localparam int D = 4;

  typedef struct {
    logic [W-1:0] data;
    logic         mm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   acc_m = 0;
  int   acc_l = 0;
  logic stuck0_m = 1'b0;
  logic prev_ov_m = 1'b0;
  logic prev_ov_l = 1'b0;
  logic [D-1:0] chain_m = '0;
  logic [D-1:0] chain_l = '0;
  exp_t exp_m[$];
  exp_t exp_l[$];
  logic din_m[$];
  logic din_l[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  siso_seq_if #(.WIDTH(W)) bus_m ();
  siso_seq_if #(.WIDTH(W)) bus_l ();

  siso_seq #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m));
  siso_seq #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

  always @(posedge clk) begin
    if (bus_m.sr_en) chain_m <= {chain_m[D-2:0], bus_m.sr_din};
    if (bus_l.sr_en) chain_l <= {chain_l[D-2:0], bus_l.sr_din};
  end
  assign bus_m.sr_dout = stuck0_m ? 1'b0 : chain_m[D-1];
  assign bus_l.sr_dout = chain_l[D-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: serial trace, latency, and scoreboard pops on each output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_m.sr_en) din_m.push_back(bus_m.sr_din);
      if (bus_l.sr_en) din_l.push_back(bus_l.sr_din);
      if (bus_m.out_valid && !prev_ov_m) check("latency_m", 32'(cyc - acc_m), 32'd13);
      if (bus_l.out_valid && !prev_ov_l) check("latency_l", 32'(cyc - acc_l), 32'd13);
      if (bus_m.out_valid && bus_m.out_ready) begin
        if (exp_m.size() == 0) begin
          check("unexpected_out_m", 32'(bus_m.out_data), 32'hFFFF_FFFF);
        end else begin
          check("out_data_m", 32'(bus_m.out_data), 32'(exp_m[0].data));
`ifdef SISO_SEQ_CHECK_EN
          check("mismatch_m", 32'(bus_m.mismatch), 32'(exp_m[0].mm));
`endif
          exp_m.delete(0);
        end
      end
      if (bus_l.out_valid && bus_l.out_ready) begin
        if (exp_l.size() == 0) begin
          check("unexpected_out_l", 32'(bus_l.out_data), 32'hFFFF_FFFF);
        end else begin
          check("out_data_l", 32'(bus_l.out_data), 32'(exp_l[0].data));
          exp_l.delete(0);
        end
      end
    end
    prev_ov_m <= bus_m.out_valid;
    prev_ov_l <= bus_l.out_valid;
  end

  task automatic send(input bit sel_l, input logic [W-1:0] d, input logic [W-1:0] ed, input logic emm);
    exp_t e;
    bit   ok;
    e.data = ed;
    e.mm   = emm;
    ok     = 1'b0;
    @(posedge clk);
    #2;
    if (sel_l) begin
      exp_l.push_back(e);
      bus_l.in_data  = d;
      bus_l.in_valid = 1'b1;
    end else begin
      exp_m.push_back(e);
      bus_m.in_data  = d;
      bus_m.in_valid = 1'b1;
    end
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if ((sel_l && bus_l.in_ready) || (!sel_l && bus_m.in_ready)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (sel_l) begin
      acc_l = cyc;
      din_l.delete();
    end else begin
      acc_m = cyc;
      din_m.delete();
    end
    #1;
    bus_m.in_valid = 1'b0;
    bus_l.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (exp_m.size() == 0 && exp_l.size() == 0) break;
    end
    check("drain", 32'(exp_m.size() + exp_l.size()), 32'd0);
    @(posedge clk);
    #2;
  endtask

  task automatic check_trace(input string name, input bit sel_l, input logic [11:0] exp);
    logic [11:0] got;
    int          sz;
    got = 12'd0;
    sz  = sel_l ? din_l.size() : din_m.size();
    check({name, "_len"}, 32'(sz), 32'd12);
    for (int i = 0; i < sz && i < 12; i++) begin
      got = {got[10:0], sel_l ? din_l[i] : din_m[i]};
    end
    check(name, 32'(got), 32'(exp));
  endtask

  initial begin
    int t0;
    bus_m.in_valid = 1'b0; bus_m.in_data = '0; bus_m.out_ready = 1'b1;
    bus_l.in_valid = 1'b0; bus_l.in_data = '0; bus_l.out_ready = 1'b1;

    // Reset while idle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus_m.in_ready), 32'd0);
    check("rst_sr_en", 32'(bus_m.sr_en), 32'd0);
    check("rst_out_valid", 32'(bus_m.out_valid), 32'd0);
    check("rst_busy", 32'(bus_m.busy), 32'd0);
    check("rst_out_data", 32'(bus_m.out_data), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle_in_ready", 32'(bus_m.in_ready), 32'd1);
    check("idle_busy", 32'(bus_m.busy), 32'd0);
    check("idle_sr_en", 32'(bus_m.sr_en), 32'd0);

    // Loopback, MSB first.
    send(1'b0, 8'hB3, 8'hB3, 1'b0);
    drain();
    check_trace("din_msb_B3", 1'b0, 12'hB30);

    // Loopback, LSB first.
    send(1'b1, 8'h01, 8'h01, 1'b0);
    drain();
    check_trace("din_lsb_01", 1'b1, 12'h800);

    // Backpressure in HOLD.
    bus_m.out_ready = 1'b0;
    send(1'b0, 8'hB3, 8'hB3, 1'b0);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus_m.out_valid) break;
    end
    check("bp_valid_seen", 32'(bus_m.out_valid), 32'd1);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(bus_m.out_valid), 32'd1);
      check("bp_out_data", 32'(bus_m.out_data), 32'hB3);
      check("bp_in_ready", 32'(bus_m.in_ready), 32'd0);
      check("bp_sr_en", 32'(bus_m.sr_en), 32'd0);
    end
    @(posedge clk);
    #2 bus_m.out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_pre", 32'(bus_m.in_ready), 32'd0);
    @(negedge clk);
    check("bp_in_ready_post", 32'(bus_m.in_ready), 32'd1);
    check("bp_valid_drop", 32'(bus_m.out_valid), 32'd0);
    drain();

    // Reset mid-SHIFT at k=3, then a clean word.
    send(1'b0, 8'hFF, 8'hFF, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(bus_m.in_ready), 32'd0);
    check("mid_rst_sr_en", 32'(bus_m.sr_en), 32'd0);
    check("mid_rst_sr_din", 32'(bus_m.sr_din), 32'd0);
    check("mid_rst_busy", 32'(bus_m.busy), 32'd0);
    check("mid_rst_out_data", 32'(bus_m.out_data), 32'd0);
    exp_m.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    send(1'b0, 8'h5A, 8'h5A, 1'b0);
    drain();

    // Back-to-back throughput.
    send(1'b0, 8'hC5, 8'hC5, 1'b0);
    t0 = acc_m;
    send(1'b0, 8'h3A, 8'h3A, 1'b0);
    check("throughput", 32'(acc_m - t0), 32'd15);
    drain();

    // Stuck-at-0 chain, then a healthy chain.
    stuck0_m = 1'b1;
    send(1'b0, 8'hFF, 8'h00, 1'b1);
    drain();
    stuck0_m = 1'b0;
    send(1'b0, 8'h3C, 8'h3C, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
